// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with stall, fault, timeout and MEM/WB register
module mem_access_unit #(
   parameter int DMEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] DataWM,
   input  logic [4:0]  RdM,
   input  logic        RegWriteM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic        FaultM,
   output logic [31:0] ResultW,
   output logic [4:0]  RdW,
   output logic        RegWriteW
);
   localparam int CW = $clog2(DMEM_TIMEOUT + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
   logic [3:0] be_q, be_d;
   logic [2:0] f3_q, f3_d;
   logic [1:0] off_q, off_d;
   logic [4:0] rd_q, rd_d, rdw_q, rdw_d;
   logic we_q, we_d, rw_q, rw_d, rww_q, rww_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic bad;
   logic [3:0] be_c;
   logic [31:0] wd_c, sh, ld;
   assign bad = (MemReadM & MemWriteM)
              | (MemReadM & (Funct3M == 3'b011 | Funct3M[2:1] == 2'b11))
              | (MemWriteM & (Funct3M[2] | Funct3M == 3'b011))
              | (Funct3M[1:0] == 2'b01 & ALUResultM[0])
              | (Funct3M[1:0] == 2'b10 & |ALUResultM[1:0]);
   assign be_c = !MemWriteM ? 4'b0000 : Funct3M[1] ? 4'b1111 :
                 Funct3M[0] ? 4'b0011 << ALUResultM[1:0] : 4'b0001 << ALUResultM[1:0];
   assign wd_c = Funct3M[1] ? DataWM : Funct3M[0] ? {2{DataWM[15:0]}} : {4{DataWM[7:0]}};
   assign sh = dmem_rdata >> {off_q, 3'b000};
   assign ld = f3_q[1] ? dmem_rdata :
               f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
   assign dmem_req = state_q == BUSY;
   assign dmem_we = we_q & dmem_req;
   assign dmem_addr = addr_q;
   assign dmem_wdata = wdata_q;
   assign dmem_be = be_q;
   assign ResultW = res_q;
   assign RdW = rdw_q;
   assign RegWriteW = rww_q;
   // next state, request latching, stall/fault and MEM/WB contents (bubble unless stated)
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      be_d = be_q;
      we_d = we_q;
      f3_d = f3_q;
      off_d = off_q;
      rd_d = rd_q;
      rw_d = rw_q;
      cnt_d = cnt_q;
      res_d = '0;
      rdw_d = '0;
      rww_d = 1'b0;
      StallM = 1'b0;
      FaultM = 1'b0;
      if (state_q == IDLE) begin
         if (!MemReadM && !MemWriteM) begin
            res_d = ALUResultM;
            rww_d = RegWriteM;
            rdw_d = RegWriteM ? RdM : '0;
         end else if (bad) begin
            FaultM = 1'b1;
         end else begin
            StallM = 1'b1;
            state_d = BUSY;
            addr_d = {ALUResultM[31:2], 2'b00};
            off_d = ALUResultM[1:0];
            we_d = MemWriteM;
            be_d = be_c;
            wdata_d = wd_c;
            f3_d = Funct3M;
            rd_d = RdM;
            rw_d = RegWriteM;
            cnt_d = '0;
         end
      end else if (dmem_ready) begin
         state_d = IDLE;
         cnt_d = '0;
         res_d = we_q ? '0 : ld;
         rww_d = ~we_q & rw_q;
         rdw_d = (~we_q & rw_q) ? rd_q : '0;
      end else if (cnt_q == CW'(DMEM_TIMEOUT - 1)) begin
         FaultM = 1'b1;
         state_d = IDLE;
         cnt_d = '0;
      end else begin
         StallM = 1'b1;
         cnt_d = cnt_q + 1'b1;
      end
   end
   // state and pipeline registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q <= '0;
         wdata_q <= '0;
         be_q <= '0;
         we_q <= 1'b0;
         f3_q <= '0;
         off_q <= '0;
         rd_q <= '0;
         rw_q <= 1'b0;
         cnt_q <= '0;
         res_q <= '0;
         rdw_q <= '0;
         rww_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         be_q <= be_d;
         we_q <= we_d;
         f3_q <= f3_d;
         off_q <= off_d;
         rd_q <= rd_d;
         rw_q <= rw_d;
         cnt_q <= cnt_d;
         res_q <= res_d;
         rdw_q <= rdw_d;
         rww_q <= rww_d;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random checks of mem_access_unit against an arithmetic model
module tb_mem_access_unit;
   localparam int TO = 16;
   logic clk = 1'b0, reset = 1'b1;
   logic MemReadM = 1'b0, MemWriteM = 1'b0, RegWriteM = 1'b0, dmem_ready = 1'b0;
   logic [2:0] Funct3M = '0;
   logic [31:0] ALUResultM = '0, DataWM = '0, dmem_rdata = '0;
   logic [4:0] RdM = '0;
   logic dmem_req, dmem_we, StallM, FaultM, RegWriteW;
   logic [31:0] dmem_addr, dmem_wdata, ResultW;
   logic [3:0] dmem_be;
   logic [4:0] RdW;
   int total = 0, bad = 0;
   mem_access_unit #(.DMEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .DataWM(DataWM), .RdM(RdM), .RegWriteM(RegWriteM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .StallM(StallM),
      .FaultM(FaultM), .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) & 32'hFF;
      h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      case (f3)
         3'd0: return b >= 128 ? b - 256 : b;
         3'd1: return h >= 32768 ? h - 65536 : h;
         3'd4: return b;
         3'd5: return h;
         default: return w;
      endcase
   endfunction
   // one MEM-stage instruction; lat = BUSY cycles without ready before ready rises
   task automatic do_op(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] rd, input logic rw, input int lat,
                        input logic [31:0] rdata);
      logic ill, mis;
      logic [31:0] ea, be, wd;
      int sz;
      sz = f3 % 4;
      ill = (r && w) || (r && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (w && f3 > 2);
      mis = (r || w) && ((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0));
      MemReadM = r; MemWriteM = w; Funct3M = f3; ALUResultM = a; DataWM = d; RdM = rd; RegWriteM = rw;
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      #1;
      if (!r && !w) begin
         check("pass_stall", StallM, 0);
         check("pass_fault", FaultM, 0);
         tick();
         check("pass_res", ResultW, a);
         check("pass_rd", RdW, rw ? rd : 0);
         check("pass_rw", RegWriteW, rw);
      end else if (ill || mis) begin
         check("bad_fault", FaultM, 1);
         check("bad_stall", StallM, 0);
         check("bad_req", dmem_req, 0);
         tick();
         check("bad_rw", RegWriteW, 0);
         check("bad_rd", RdW, 0);
         check("bad_req2", dmem_req, 0);
      end else begin
         be = !w ? 0 : sz == 0 ? 1 << (a % 4) : sz == 1 ? 3 << (a % 4) : 15;
         wd = sz == 0 ? (d & 255) * 32'h0101_0101 : sz == 1 ? (d & 65535) * 32'h0001_0001 : d;
         ea = a - a % 4;
         check("go_stall", StallM, 1);
         check("go_fault", FaultM, 0);
         check("go_req", dmem_req, 0);
         tick();
         check("go_rw", RegWriteW, 0);
         for (int k = 0; k < 100; k++) begin
            check("busy_req", dmem_req, 1);
            check("busy_addr", dmem_addr, ea);
            check("busy_we", dmem_we, w);
            check("busy_be", dmem_be, be);
            if (w) check("busy_wdata", dmem_wdata, wd);
            if (k == lat) begin
               dmem_ready = 1'b1;
               dmem_rdata = rdata;
               #1;
               check("done_stall", StallM, 0);
               check("done_fault", FaultM, 0);
               tick();
               dmem_ready = 1'b0;
               check("done_rw", RegWriteW, r && rw);
               check("done_rd", RdW, (r && rw) ? rd : 0);
               if (r) check("done_res", ResultW, ld_val(f3, a, rdata));
               check("done_req", dmem_req, 0);
               break;
            end else if (k == TO - 1) begin
               #1;
               check("to_fault", FaultM, 1);
               check("to_stall", StallM, 0);
               tick();
               check("to_req", dmem_req, 0);
               check("to_rw", RegWriteW, 0);
               break;
            end else begin
               #1;
               check("wait_stall", StallM, 1);
               check("wait_fault", FaultM, 0);
               tick();
               check("wait_rw", RegWriteW, 0);
            end
         end
      end
      MemReadM = 1'b0; MemWriteM = 1'b0; RegWriteM = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      reset = 1'b0;
      check("rst_req", dmem_req, 0);
      check("rst_we", dmem_we, 0);
      check("rst_be", dmem_be, 0);
      check("rst_addr", dmem_addr, 0);
      check("rst_wdata", dmem_wdata, 0);
      check("rst_stall", StallM, 0);
      check("rst_fault", FaultM, 0);
      check("rst_res", ResultW, 0);
      check("rst_rd", RdW, 0);
      check("rst_rw", RegWriteW, 0);
      do_op(0, 0, 3'd0, 32'h1234, 0, 5'd5, 1, 0, 0);
      do_op(1, 0, 3'd0, 32'h103, 0, 5'd7, 1, 0, 32'h80FF_FF7F);
      do_op(0, 1, 3'd1, 32'h202, 32'hDEAD_BEEF, 5'd9, 1, 0, 0);
      do_op(1, 0, 3'd2, 32'h101, 0, 5'd4, 1, 0, 0);
      do_op(1, 0, 3'd5, 32'h10, 0, 5'd11, 1, 3, 32'h1234_9ABC);
      do_op(1, 0, 3'd2, 32'h80, 0, 5'd12, 1, 40, 0);
      do_op(1, 0, 3'd2, 32'h84, 0, 5'd13, 1, TO - 1, 32'hCAFE_F00D);
      do_op(1, 1, 3'd2, 32'h88, 0, 5'd14, 1, 0, 0);
      do_op(0, 1, 3'd4, 32'h8C, 0, 5'd14, 1, 0, 0);
      MemReadM = 1'b0; RegWriteM = 1'b1; ALUResultM = 32'h55; RdM = 5'd6; dmem_ready = 1'b1;
      #1;
      check("idle_rdy_req", dmem_req, 0);
      check("idle_rdy_stall", StallM, 0);
      tick();
      check("idle_rdy_req2", dmem_req, 0);
      check("idle_rdy_res", ResultW, 32'h55);
      dmem_ready = 1'b0;
      MemReadM = 1'b1; Funct3M = 3'd2; ALUResultM = 32'h40; RdM = 5'd3; RegWriteM = 1'b1;
      tick();
      check("rb_req1", dmem_req, 1);
      tick();
      check("rb_req2", dmem_req, 1);
      reset = 1'b1;
      MemReadM = 1'b0; RegWriteM = 1'b0; ALUResultM = 0; RdM = 0;
      tick();
      reset = 1'b0;
      check("rb_req", dmem_req, 0);
      check("rb_we", dmem_we, 0);
      check("rb_be", dmem_be, 0);
      check("rb_addr", dmem_addr, 0);
      check("rb_wdata", dmem_wdata, 0);
      check("rb_stall", StallM, 0);
      check("rb_fault", FaultM, 0);
      check("rb_res", ResultW, 0);
      check("rb_rd", RdW, 0);
      check("rb_rw", RegWriteW, 0);
      dmem_ready = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      tick();
      check("rb_late_req", dmem_req, 0);
      check("rb_late_rw", RegWriteW, 0);
      check("rb_late_res", ResultW, 0);
      dmem_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
         int kind;
         kind = $urandom_range(0, 9);
         do_op(kind >= 5 && kind != 9 || kind == 1, kind >= 2 && kind <= 4 || kind == 1,
               3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0) ? 30 : $urandom_range(0, 3),
               $urandom);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DMEM_TIMEOUT, 16, max cycles in BUSY before abort.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clk only.
REQ-004 MemReadM, MemWriteM  in  1 each  load or store request for the instruction currently in MEM.
REQ-005 Funct3M  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use only 000/001/010).
REQ-006 ALUResultM  in  32  effective address or non-memory result.
REQ-007 DataWM  in  32  store data, right-aligned.
REQ-008 RdM  in  5  destination register.
REQ-009 RegWriteM  in  1  write-back enable.
REQ-010 dmem_req, dmem_we  out  1 each  memory request and write strobe.
REQ-011 dmem_addr  out  32  word address, bits [1:0] always 0.
REQ-012 dmem_wdata  out  32  lane-replicated store data.
REQ-013 dmem_be  out  4  byte enables.
REQ-014 dmem_ready  in  1  memory completion strobe.
REQ-015 dmem_rdata  in  32  read word, valid when dmem_ready=1.
REQ-016 StallM  out  1  freeze IF..EX/MEM; upstream holds all M inputs while high.
REQ-017 FaultM  out  1  one-cycle pulse on misaligned, illegal or timed-out access.
REQ-018 ResultW, RdW, RegWriteW  out  32/5/1  MEM/WB register contents.

Function
REQ-019 FSM states IDLE, BUSY; IDLE is the only state with dmem_req=0.
REQ-020 Access = MemReadM xor MemWriteM; MemReadM and MemWriteM both high is illegal.
REQ-021 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0; illegal: reserved Funct3M for the operation type.
REQ-022 IDLE, no access: MEM/WB loads {ALUResultM, RdM, RegWriteM} every cycle, StallM=0.
REQ-023 IDLE, misaligned or illegal: no request; FaultM=1 for that cycle; MEM/WB loads RegWriteW=0; StallM=0.
REQ-024 IDLE, valid access: StallM=1, MEM/WB loads bubble (RegWriteW=0), latch address/we/be/wdata/Funct3/Rd/RegWrite, go BUSY next cycle.
REQ-025 BUSY: dmem_req=1; dmem_addr/we/be/wdata held constant from latched values until dmem_ready.
REQ-026 BUSY, dmem_ready=0: StallM=1, MEM/WB loads bubble, timeout counter increments.
REQ-027 BUSY, dmem_ready=1: StallM=0; MEM/WB loads extended load data (load) or RegWriteW=0 (store); next state IDLE.
REQ-028 Minimum load/store latency: 2 cycles of MEM occupancy (1 stall cycle) when dmem_ready is high in the first BUSY cycle.
REQ-029 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; 0000 for loads.
REQ-030 Store data: B replicated x4 from DataWM[7:0]; H replicated x2 from DataWM[15:0]; W unchanged.
REQ-031 Load extract selects byte/half by latched addr[1:0]; B/H sign-extend from bit 7/15; BU/HU zero-extend.
REQ-032 Timeout: counter reaching DMEM_TIMEOUT in BUSY without dmem_ready -> FaultM=1, bubble, StallM=0, IDLE next cycle.
REQ-033 dmem_ready while IDLE is ignored.
REQ-034 RdW forced 0 whenever RegWriteW=0.

Reset
REQ-035 Reset: state IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, StallM=0, FaultM=0, ResultW=0, RdW=0, RegWriteW=0, counter 0.
REQ-036 Reset asserted in BUSY aborts the access: dmem_req=0 in the cycle after the reset edge; late dmem_ready ignored.

Verification
REQ-037 ALU pass-through: MemReadM=0, MemWriteM=0, ALUResultM=0x1234, RdM=5, RegWriteM=1 -> next cycle ResultW=0x1234, RdW=5, RegWriteW=1, StallM=0.
REQ-038 LB signed: addr 0x103, dmem_rdata 0x80FF_FF7F, ready in first BUSY cycle -> dmem_addr=0x100, one stall cycle, ResultW=0xFFFF_FF80.
REQ-039 SH: addr 0x202, DataWM=0xDEAD_BEEF -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, RegWriteW=0.
REQ-040 Misaligned LW at 0x101 -> FaultM pulse, no dmem_req, RegWriteW=0, StallM=0.
REQ-041 LHU addr 0x10, dmem_ready low 3 cycles -> StallM high 4 cycles, request signals stable, ResultW=zero-extended half[15:0].
REQ-042 Reset asserted in second BUSY cycle -> next cycle IDLE, dmem_req=0, all outputs at reset values.
